ascon_ctrl_fsm: RTL and testbench

Sequencing controller for the ASCON-AEAD128 datapath. It runs one complete encryption pass:
- initialisation with p^12;
- `NB_AD` associated-data blocks with p^8;
- `NB_PT` plaintext blocks, each XORed in and emitted as ciphertext, with p^8 between blocks;
- finalisation with p^12 and tag emission.

It drives the external round counter (load-to-0 / load-to-4 / increment) and all state-register, XOR and output enables of the permutation datapath. It handshakes with the data source one block at a time.

---
 rtl/ascon_pack.sv | 42 ++++
 rtl/compteur_bloc.sv | 34 +++
 rtl/ascon_ctrl_fsm.sv | 168 ++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON-AEAD128 control path.
package ascon_pack;

  localparam int unsigned ROUND_W   = 4;
  localparam int unsigned BLK_CNT_W = 4;

  localparam logic [ROUND_W-1:0] ROUND_P12_FIRST = ROUND_W'(0);
  localparam logic [ROUND_W-1:0] ROUND_P8_FIRST  = ROUND_W'(4);
  localparam logic [ROUND_W-1:0] ROUND_LAST      = ROUND_W'(11);

  typedef enum logic [3:0] {
    IDLE,
    CONF_INIT,
    INIT,
    WAIT_AD,
    CONF_AD,
    AD,
    WAIT_PT,
    CONF_PT,
    PT,
    CONF_FIN,
    FIN
  } ctrl_state_t;

  // Control word driven to the round counter and permutation datapath.
  typedef struct packed {
    logic cpt_en;
    logic cpt_init_a;
    logic cpt_init_b;
    logic en_state;
    logic sel_init;
    logic en_xor_data_begin;
    logic en_xor_key_begin;
    logic en_xor_key_end;
    logic en_xor_dsep_end;
    logic en_cipher;
    logic en_tag;
    logic busy;
    logic done;
  } ctrl_out_t;

endpackage

// File: rtl/compteur_bloc.sv
// Block counter: counts completed AD/PT blocks of the current phase.
module compteur_bloc
  import ascon_pack::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear_i,
  input  logic                 en_i,
  output logic [BLK_CNT_W-1:0] cnt_o
);

  logic [BLK_CNT_W-1:0] cnt_d;
  logic [BLK_CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + BLK_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Sequencing controller for one ASCON-AEAD128 encryption pass:
// init p^12, NB_AD AD blocks, NB_PT PT blocks, final p^12 with tag.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int unsigned NB_AD = 1,
  parameter int unsigned NB_PT = 4
) (
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               start_i,
  input  logic               data_valid_i,
  input  logic [ROUND_W-1:0] round_i,
  output logic               cpt_en_o,
  output logic               cpt_init_a_o,
  output logic               cpt_init_b_o,
  output logic               en_state_o,
  output logic               sel_init_o,
  output logic               en_xor_data_begin_o,
  output logic               en_xor_key_begin_o,
  output logic               en_xor_key_end_o,
  output logic               en_xor_dsep_end_o,
  output logic               en_cipher_o,
  output logic               en_tag_o,
  output logic               busy_o,
  output logic               done_o
);

  // Counter value while the last block of each phase is being handled.
  localparam logic [BLK_CNT_W-1:0] LAST_AD = BLK_CNT_W'(NB_AD - 1);
  localparam logic [BLK_CNT_W-1:0] LAST_PT = BLK_CNT_W'(NB_PT - 1);

  ctrl_state_t          state_d;
  ctrl_state_t          state_q;
  logic                 blk_clr_c;
  logic                 blk_inc_c;
  logic [BLK_CNT_W-1:0] blk_cnt;
  ctrl_out_t            ctrl_c;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and block-counter control.
  always_comb begin
    state_d   = state_q;
    blk_clr_c = 1'b0;
    blk_inc_c = 1'b0;
    case (state_q)
      IDLE: begin
        blk_clr_c = 1'b1;
        if (start_i) state_d = CONF_INIT;
      end
      CONF_INIT: state_d = INIT;
      INIT: begin
        if (round_i == ROUND_LAST) state_d = WAIT_AD;
      end
      WAIT_AD: begin
        if (data_valid_i) state_d = CONF_AD;
      end
      CONF_AD: state_d = AD;
      AD: begin
        if (round_i == ROUND_LAST) begin
          if (blk_cnt == LAST_AD) begin
            blk_clr_c = 1'b1;
            state_d   = WAIT_PT;
          end else begin
            blk_inc_c = 1'b1;
            state_d   = WAIT_AD;
          end
        end
      end
      WAIT_PT: begin
        if (data_valid_i) state_d = (blk_cnt == LAST_PT) ? CONF_FIN : CONF_PT;
      end
      CONF_PT: state_d = PT;
      PT: begin
        if (round_i == ROUND_LAST) begin
          blk_inc_c = 1'b1;
          state_d   = WAIT_PT;
        end
      end
      CONF_FIN: state_d = FIN;
      FIN: begin
        if (round_i == ROUND_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state and round index; the last PT block is absorbed in FIN.
  always_comb begin
    ctrl_c = '0;
    case (state_q)
      CONF_INIT, CONF_FIN: begin
        ctrl_c.busy       = 1'b1;
        ctrl_c.cpt_en     = 1'b1;
        ctrl_c.cpt_init_a = 1'b1;
      end
      CONF_AD, CONF_PT: begin
        ctrl_c.busy       = 1'b1;
        ctrl_c.cpt_en     = 1'b1;
        ctrl_c.cpt_init_b = 1'b1;
      end
      WAIT_AD, WAIT_PT: ctrl_c.busy = 1'b1;
      INIT: begin
        ctrl_c.busy           = 1'b1;
        ctrl_c.cpt_en         = 1'b1;
        ctrl_c.en_state       = 1'b1;
        ctrl_c.sel_init       = (round_i == ROUND_P12_FIRST);
        ctrl_c.en_xor_key_end = (round_i == ROUND_LAST);
      end
      AD: begin
        ctrl_c.busy              = 1'b1;
        ctrl_c.cpt_en            = 1'b1;
        ctrl_c.en_state          = 1'b1;
        ctrl_c.en_xor_data_begin = (round_i == ROUND_P8_FIRST);
        ctrl_c.en_xor_dsep_end   = (round_i == ROUND_LAST) && (blk_cnt == LAST_AD);
      end
      PT: begin
        ctrl_c.busy              = 1'b1;
        ctrl_c.cpt_en            = 1'b1;
        ctrl_c.en_state          = 1'b1;
        ctrl_c.en_xor_data_begin = (round_i == ROUND_P8_FIRST);
        ctrl_c.en_cipher         = (round_i == ROUND_P8_FIRST);
      end
      FIN: begin
        ctrl_c.busy              = 1'b1;
        ctrl_c.cpt_en            = 1'b1;
        ctrl_c.en_state          = 1'b1;
        ctrl_c.en_xor_data_begin = (round_i == ROUND_P12_FIRST);
        ctrl_c.en_cipher         = (round_i == ROUND_P12_FIRST);
        ctrl_c.en_xor_key_begin  = (round_i == ROUND_P12_FIRST);
        ctrl_c.en_xor_key_end    = (round_i == ROUND_LAST);
        ctrl_c.en_tag            = (round_i == ROUND_LAST);
        ctrl_c.done              = (round_i == ROUND_LAST);
      end
      default: ctrl_c = '0;
    endcase
  end

  compteur_bloc u_blk_cnt (
    .clk     (clock_i),
    .rst_n   (resetb_i),
    .clear_i (blk_clr_c),
    .en_i    (blk_inc_c),
    .cnt_o   (blk_cnt)
  );

  assign cpt_en_o            = ctrl_c.cpt_en;
  assign cpt_init_a_o        = ctrl_c.cpt_init_a;
  assign cpt_init_b_o        = ctrl_c.cpt_init_b;
  assign en_state_o          = ctrl_c.en_state;
  assign sel_init_o          = ctrl_c.sel_init;
  assign en_xor_data_begin_o = ctrl_c.en_xor_data_begin;
  assign en_xor_key_begin_o  = ctrl_c.en_xor_key_begin;
  assign en_xor_key_end_o    = ctrl_c.en_xor_key_end;
  assign en_xor_dsep_end_o   = ctrl_c.en_xor_dsep_end;
  assign en_cipher_o         = ctrl_c.en_cipher;
  assign en_tag_o            = ctrl_c.en_tag;
  assign busy_o              = ctrl_c.busy;
  assign done_o              = ctrl_c.done;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: phase-level schedule model, per-cycle compare, literal pins.
module tb_ascon_ctrl_fsm;

  localparam int B_CPT = 12, B_IA = 11, B_IB = 10, B_ST = 9, B_SEL = 8, B_XDB = 7;
  localparam int B_XKB = 6, B_XKE = 5, B_XDS = 4, B_CIP = 3, B_TAG = 2, B_BUSY = 1, B_DONE = 0;

  localparam logic [12:0] M_CPT  = 13'd1 << B_CPT;
  localparam logic [12:0] M_IA   = 13'd1 << B_IA;
  localparam logic [12:0] M_IB   = 13'd1 << B_IB;
  localparam logic [12:0] M_ST   = 13'd1 << B_ST;
  localparam logic [12:0] M_SEL  = 13'd1 << B_SEL;
  localparam logic [12:0] M_XDB  = 13'd1 << B_XDB;
  localparam logic [12:0] M_XKB  = 13'd1 << B_XKB;
  localparam logic [12:0] M_XKE  = 13'd1 << B_XKE;
  localparam logic [12:0] M_XDS  = 13'd1 << B_XDS;
  localparam logic [12:0] M_CIP  = 13'd1 << B_CIP;
  localparam logic [12:0] M_TAG  = 13'd1 << B_TAG;
  localparam logic [12:0] M_BUSY = 13'd1 << B_BUSY;
  localparam logic [12:0] M_DONE = 13'd1 << B_DONE;

  typedef enum {K_INIT, K_AD, K_ADLAST, K_PT, K_FIN} perm_kind_t;

  logic clk = 1'b0;
  logic resetb = 1'b0;
  logic start_a = 1'b0, dv_a = 1'b0, start_b = 1'b0, dv_b = 1'b0;
  logic [3:0] round_a, round_b;
  wire  [12:0] obs_a, obs_b;

  always #5 clk = ~clk;

  ascon_ctrl_fsm u_dut_a (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_a), .data_valid_i(dv_a), .round_i(round_a),
    .cpt_en_o(obs_a[B_CPT]), .cpt_init_a_o(obs_a[B_IA]), .cpt_init_b_o(obs_a[B_IB]),
    .en_state_o(obs_a[B_ST]), .sel_init_o(obs_a[B_SEL]), .en_xor_data_begin_o(obs_a[B_XDB]),
    .en_xor_key_begin_o(obs_a[B_XKB]), .en_xor_key_end_o(obs_a[B_XKE]),
    .en_xor_dsep_end_o(obs_a[B_XDS]), .en_cipher_o(obs_a[B_CIP]), .en_tag_o(obs_a[B_TAG]),
    .busy_o(obs_a[B_BUSY]), .done_o(obs_a[B_DONE])
  );

  ascon_ctrl_fsm #(.NB_AD(2), .NB_PT(1)) u_dut_b (
    .clock_i(clk), .resetb_i(resetb), .start_i(start_b), .data_valid_i(dv_b), .round_i(round_b),
    .cpt_en_o(obs_b[B_CPT]), .cpt_init_a_o(obs_b[B_IA]), .cpt_init_b_o(obs_b[B_IB]),
    .en_state_o(obs_b[B_ST]), .sel_init_o(obs_b[B_SEL]), .en_xor_data_begin_o(obs_b[B_XDB]),
    .en_xor_key_begin_o(obs_b[B_XKB]), .en_xor_key_end_o(obs_b[B_XKE]),
    .en_xor_dsep_end_o(obs_b[B_XDS]), .en_cipher_o(obs_b[B_CIP]), .en_tag_o(obs_b[B_TAG]),
    .busy_o(obs_b[B_BUSY]), .done_o(obs_b[B_DONE])
  );

  // External round counters driven by each controller.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) round_a <= 4'd0;
    else if (obs_a[B_CPT]) round_a <= obs_a[B_IA] ? 4'd0 : (obs_a[B_IB] ? 4'd4 : round_a + 4'd1);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) round_b <= 4'd0;
    else if (obs_b[B_CPT]) round_b <= obs_b[B_IA] ? 4'd0 : (obs_b[B_IB] ? 4'd4 : round_b + 4'd1);
  end

  // Expected schedule of one pass: entry k describes cycle k+1 after the start sample.
  logic [12:0] sch_out[$];
  bit          sch_dv[$];
  bit          sch_st[$];
  int          stall_ad[16];
  int          stall_pt[16];

  int          sel = 0;
  bit          chk_on = 1'b0;
  int          cur_cycle = -1;
  logic [12:0] exp_cur = '0;
  bit          lit_req = 1'b0;
  int          lx_done, lx_st, lx_cip, lx_ia, lx_ib, lx_dsep, lx_xkb;

  int n_chk = 0, n_fail = 0;
  int cnt_st, cnt_cip, cnt_tag, cnt_ia, cnt_ib;
  int done_cycle, dsep_cycle, xkb_cycle, cip_last;

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Compare process: every checked cycle plus the end-of-pass literal pins.
  initial begin
    logic [12:0] obs;
    forever begin
      @(negedge clk or negedge resetb);
      #1;
      if (chk_on) begin
        obs = (sel == 0) ? obs_a : obs_b;
        if (cur_cycle == 0) begin
          cnt_st = 0; cnt_cip = 0; cnt_tag = 0; cnt_ia = 0; cnt_ib = 0;
          done_cycle = -1; dsep_cycle = -1; xkb_cycle = -1; cip_last = -1;
        end
        n_chk++;
        if (obs !== exp_cur) begin
          n_fail++;
          $display("FAIL out_vec dut%0d cycle %0d: got %b want %b", sel, cur_cycle, obs, exp_cur);
        end
        cnt_st  += int'(obs[B_ST]);
        cnt_cip += int'(obs[B_CIP]);
        cnt_tag += int'(obs[B_TAG]);
        cnt_ia  += int'(obs[B_IA]);
        cnt_ib  += int'(obs[B_IB]);
        if (obs[B_DONE]) done_cycle = cur_cycle;
        if (obs[B_XDS] && dsep_cycle < 0) dsep_cycle = cur_cycle;
        if (obs[B_XKB]) xkb_cycle = cur_cycle;
        if (obs[B_CIP]) cip_last = cur_cycle;
        if (lit_req) begin
          chk("done_cycle", done_cycle, lx_done);
          chk("en_state_count", cnt_st, lx_st);
          chk("en_cipher_count", cnt_cip, lx_cip);
          chk("en_tag_count", cnt_tag, 1);
          chk("cpt_init_a_count", cnt_ia, lx_ia);
          chk("cpt_init_b_count", cnt_ib, lx_ib);
          chk("dsep_cycle", dsep_cycle, lx_dsep);
          chk("key_begin_cycle", xkb_cycle, lx_xkb);
          chk("last_cipher_cycle", cip_last, lx_xkb);
        end
      end
    end
  end

  task automatic push(input bit dv, input logic [12:0] o);
    sch_out.push_back(o);
    sch_dv.push_back(dv);
    sch_st.push_back(1'b0);
  endtask

  task automatic seg_conf(input bit load_zero, input bit dv);
    push(dv, M_BUSY | M_CPT | (load_zero ? M_IA : M_IB));
  endtask

  task automatic seg_wait(input int stalls);
    for (int i = 0; i < stalls; i++) push(1'b0, M_BUSY);
    push(1'b1, M_BUSY);
  endtask

  task automatic seg_perm(input perm_kind_t kind, input bit dv);
    int first;
    logic [12:0] o;
    first = (kind == K_INIT || kind == K_FIN) ? 0 : 4;
    for (int r = first; r <= 11; r++) begin
      o = M_BUSY | M_ST | M_CPT;
      case (kind)
        K_INIT:   begin if (r == 0) o |= M_SEL; if (r == 11) o |= M_XKE; end
        K_AD:     begin if (r == 4) o |= M_XDB; end
        K_ADLAST: begin if (r == 4) o |= M_XDB; if (r == 11) o |= M_XDS; end
        K_PT:     begin if (r == 4) o |= M_XDB | M_CIP; end
        K_FIN:    begin if (r == 0) o |= M_XDB | M_CIP | M_XKB; if (r == 11) o |= M_XKE | M_TAG | M_DONE; end
        default:  o = o;
      endcase
      push(dv, o);
    end
  endtask

  task automatic build(input int nb_ad, input int nb_pt, input bit dv_other);
    sch_out.delete(); sch_dv.delete(); sch_st.delete();
    seg_conf(1'b1, dv_other);
    seg_perm(K_INIT, dv_other);
    for (int i = 1; i <= nb_ad; i++) begin
      seg_wait(stall_ad[i]);
      seg_conf(1'b0, dv_other);
      seg_perm((i == nb_ad) ? K_ADLAST : K_AD, dv_other);
    end
    for (int j = 1; j < nb_pt; j++) begin
      seg_wait(stall_pt[j]);
      seg_conf(1'b0, dv_other);
      seg_perm(K_PT, dv_other);
    end
    seg_wait(stall_pt[nb_pt]);
    seg_conf(1'b1, dv_other);
    seg_perm(K_FIN, dv_other);
  endtask

  task automatic clear_stalls();
    for (int i = 0; i < 16; i++) begin stall_ad[i] = 0; stall_pt[i] = 0; end
  endtask

  task automatic set_in(input bit s, input bit d);
    start_a = (sel == 0) ? s : 1'b0;
    dv_a    = (sel == 0) ? d : 1'b0;
    start_b = (sel == 1) ? s : 1'b0;
    dv_b    = (sel == 1) ? d : 1'b0;
  endtask

  // Entered at posedge+1 of an idle cycle; returns at posedge+1 of the cycle after done.
  task automatic run_pass(input int inst, input int e_done, input int e_st, input int e_cip,
                          input int e_ia, input int e_ib, input int e_dsep, input int e_xkb);
    sel = inst;
    lx_done = e_done; lx_st = e_st; lx_cip = e_cip;
    lx_ia = e_ia; lx_ib = e_ib; lx_dsep = e_dsep; lx_xkb = e_xkb;
    cur_cycle = 0; exp_cur = '0; chk_on = 1'b1;
    set_in(1'b1, 1'b0);
    for (int k = 0; k < sch_out.size(); k++) begin
      @(posedge clk); #1;
      cur_cycle = k + 1;
      exp_cur = sch_out[k];
      lit_req = (k == sch_out.size() - 1);
      set_in(sch_st[k], sch_dv[k]);
    end
    @(posedge clk); #1;
    lit_req = 1'b0; cur_cycle = -1; exp_cur = '0;
    set_in(1'b0, 1'b0);
  endtask

  initial begin
    // Reset held for three cycles, then one idle cycle: everything 0.
    chk_on = 1'b1; exp_cur = '0; cur_cycle = -1;
    set_in(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3 resetb = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Full default pass, no stalls, then a back-to-back pass with stalls.
    clear_stalls();
    build(1, 4, 1'b1);
    run_pass(0, 67, 56, 4, 2, 4, 23, 56);
    stall_ad[1] = 5; stall_pt[2] = 3;
    build(1, 4, 1'b1);
    run_pass(0, 75, 56, 4, 2, 4, 28, 64);

    // NB_AD=2, NB_PT=1 variant.
    clear_stalls();
    build(2, 1, 1'b1);
    run_pass(1, 47, 40, 1, 2, 2, 33, 36);

    // Reset during PT block 1 round 7 (cycle 29), then a clean pass.
    sel = 0;
    @(posedge clk); #1;
    build(1, 4, 1'b1);
    cur_cycle = 0; exp_cur = '0; set_in(1'b1, 1'b0);
    for (int k = 0; k < 29; k++) begin
      @(posedge clk); #1;
      cur_cycle = k + 1; exp_cur = sch_out[k];
      set_in(sch_st[k], sch_dv[k]);
    end
    #2;
    exp_cur = '0; cur_cycle = -1;
    set_in(1'b0, 1'b0);
    resetb = 1'b0;
    repeat (2) @(posedge clk);
    #3 resetb = 1'b1;
    @(posedge clk); #1;
    run_pass(0, 67, 56, 4, 2, 4, 23, 56);

    // Ignored inputs: start while busy, data_valid only during INIT and WAIT cycles.
    build(1, 4, 1'b0);
    for (int i = 1; i <= 12; i++) sch_dv[i] = 1'b1;
    sch_st[4] = 1'b1; sch_st[13] = 1'b1; sch_st[29] = 1'b1; sch_st[66] = 1'b1;
    run_pass(0, 67, 56, 4, 2, 4, 23, 56);

    repeat (2) @(posedge clk);
    chk_on = 1'b0;
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
